// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with redirect, stall and halt handling
//
// Purpose: drives the instruction-memory request from the current PC, loads
// the IF/ID pipeline register on a memory hit, and returns the next PC plus
// its write enable to the program counter.  A redirect that arrives while a
// memory request is outstanding is parked until that wrong-path response
// lands, and the response is dropped.
//
// Optional feature macro: FETCH_PERF_EN (delivered-instruction and
// memory-wait counters; ports tie to 0 when undefined).
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   pc_curr              current PC from the program counter
//   pc_next, pc_en       next PC and its update enable
//   imemREN, imemaddr    instruction memory request and address
//   ihit, imemload       instruction memory data valid and read data
//   stall                hold IF/ID
//   flush, redirect_pc   kill IF/ID and redirect fetch to redirect_pc
//   halt                 stop fetching until reset
//   ifid_valid/instr/pc/npc  IF/ID pipeline register
//   perf_fetched, perf_wait  performance counters

module fetch_stage #(
  parameter int WORD_W  = 32,
  parameter int PC_INCR = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] pc_curr,
  output logic [WORD_W-1:0] pc_next,
  output logic              pc_en,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  input  logic              stall,
  input  logic              flush,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              ifid_valid,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc,
  output logic [WORD_W-1:0] ifid_npc,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_wait
);

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] redirect_q, redirect_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [WORD_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [WORD_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [WORD_W-1:0] ifid_npc_q, ifid_npc_d;
  logic [WORD_W-1:0] pc_seq;
  logic              load_en;

  // Sequential successor; wraps naturally at 2^WORD_W.
  assign pc_seq   = pc_curr + WORD_W'(PC_INCR);
  assign imemaddr = pc_curr;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (halt)               state_d = ST_HALTED;
        else if (flush && !ihit) state_d = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (halt)      state_d = ST_HALTED;
        else if (ihit) state_d = ST_FETCH;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    imemREN      = 1'b0;
    pc_en        = 1'b0;
    pc_next      = pc_seq;
    load_en      = 1'b0;
    redirect_d   = redirect_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_npc_d   = ifid_npc_q;
    case (state_q)
      ST_FETCH: begin
        imemREN = 1'b1;
        if (halt) begin
          ifid_valid_d = 1'b0;
        end else if (flush) begin
          ifid_valid_d = 1'b0;
          if (ihit) begin
            // Response belongs to the wrong path; redirect right away.
            pc_en   = 1'b1;
            pc_next = redirect_pc;
          end else begin
            redirect_d = redirect_pc;
          end
        end else if (ihit && !stall) begin
          load_en = 1'b1;
          pc_en   = 1'b1;
        end
      end
      ST_DISCARD: begin
        imemREN      = 1'b1;
        ifid_valid_d = 1'b0;
        if (!halt) begin
          if (flush) redirect_d = redirect_pc;
          if (ihit) begin
            // Newest redirect wins when a flush coincides with the response.
            pc_en   = 1'b1;
            pc_next = flush ? redirect_pc : redirect_q;
          end
        end
      end
      default: begin
        ifid_valid_d = 1'b0;
      end
    endcase
    if (load_en) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = imemload;
      ifid_pc_d    = pc_curr;
      ifid_npc_d   = pc_seq;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      redirect_q   <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_npc_q   <= '0;
    end else begin
      redirect_q   <= redirect_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_npc_q   <= ifid_npc_d;
    end
  end

  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_npc   = ifid_npc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, load_en};
    perf_wait_d    = perf_wait_q + {31'd0, (imemREN && !ihit)};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_fetched_q <= '0;
      perf_wait_q    <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_wait_q    <= perf_wait_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_wait    = perf_wait_q;
`else
  assign perf_fetched = 32'd0;
  assign perf_wait    = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        CLK, nRST;
  logic [31:0] pc_curr, pc_next, imemaddr, imemload, redirect_pc;
  logic        pc_en, imemREN, ihit, stall, flush, halt;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc, ifid_npc, perf_fetched, perf_wait;

  fetch_stage #(.WORD_W(32), .PC_INCR(4)) dut (
    .CLK(CLK), .nRST(nRST), .pc_curr(pc_curr), .pc_next(pc_next), .pc_en(pc_en),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .stall(stall), .flush(flush), .redirect_pc(redirect_pc), .halt(halt),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_npc(ifid_npc), .perf_fetched(perf_fetched), .perf_wait(perf_wait)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what mode fetch is in, where a pending redirect points,
  // what IF/ID must hold, and how many deliveries/waits have occurred.
  localparam int M_RUN = 0, M_WRONG_PATH = 1, M_STOPPED = 2;
  int          m_mode;
  logic [31:0] m_target;
  logic        m_valid;
  logic [31:0] m_instr, m_pc, m_npc;
  int unsigned m_fetched, m_wait;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_mode <= M_RUN; m_target <= 0; m_valid <= 0;
      m_instr <= 0; m_pc <= 0; m_npc <= 0; m_fetched <= 0; m_wait <= 0;
    end else begin
      if (m_mode != M_STOPPED && !ihit) m_wait <= m_wait + 1;
      if (m_mode == M_STOPPED) begin
        m_valid <= 0;
      end else if (halt) begin
        m_mode <= M_STOPPED; m_valid <= 0;
      end else if (m_mode == M_WRONG_PATH) begin
        if (flush) m_target <= redirect_pc;
        if (ihit) m_mode <= M_RUN;
      end else if (flush) begin
        m_valid <= 0;
        if (!ihit) begin m_target <= redirect_pc; m_mode <= M_WRONG_PATH; end
      end else if (ihit && !stall) begin
        m_valid <= 1; m_instr <= imemload; m_pc <= pc_curr; m_npc <= pc_curr + 32'd4;
        m_fetched <= m_fetched + 1;
      end
    end
  end

  // Single compare process, sampling mid-cycle.
  always @(negedge CLK) begin
    if (check_en) begin
      logic        e_en;
      logic [31:0] e_next;
      e_en = 0; e_next = 0;
      if (m_mode != M_STOPPED && !halt) begin
        if (m_mode == M_WRONG_PATH && ihit) begin
          e_en = 1; e_next = flush ? redirect_pc : m_target;
        end else if (m_mode == M_RUN && flush && ihit) begin
          e_en = 1; e_next = redirect_pc;
        end else if (m_mode == M_RUN && !flush && ihit && !stall) begin
          e_en = 1; e_next = pc_curr + 32'd4;
        end
      end
      chk("m_imemREN", {31'd0, imemREN}, {31'd0, m_mode != M_STOPPED});
      chk("m_imemaddr", imemaddr, pc_curr);
      chk("m_pc_en", {31'd0, pc_en}, {31'd0, e_en});
      if (e_en) chk("m_pc_next", pc_next, e_next);
      chk("m_ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("m_ifid_instr", ifid_instr, m_instr);
        chk("m_ifid_pc", ifid_pc, m_pc);
        chk("m_ifid_npc", ifid_npc, m_npc);
      end
`ifdef FETCH_PERF_EN
      chk("m_perf_fetched", perf_fetched, m_fetched);
      chk("m_perf_wait", perf_wait, m_wait);
`else
      chk("m_perf_fetched", perf_fetched, 32'd0);
      chk("m_perf_wait", perf_wait, 32'd0);
`endif
    end
  end

  task automatic drive(input logic [31:0] pc, input logic hit, input logic [31:0] load,
                       input logic stl, input logic fl, input logic [31:0] rpc, input logic hlt);
    pc_curr = pc; ihit = hit; imemload = load; stall = stl;
    flush = fl; redirect_pc = rpc; halt = hlt;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", {31'd0, ifid_valid}, 0);
    chk("rst_instr", ifid_instr, 0);
    chk("rst_imemREN", {31'd0, imemREN}, 1);
    nRST = 1;
    check_en = 1;

    // First fetch after reset
    drive(32'h0, 1, 32'h20010001, 0, 0, 0, 0);
    #2;
    chk("t1_pc_en", {31'd0, pc_en}, 1);
    chk("t1_pc_next", pc_next, 32'h4);
    tick();
    chk("t1_valid", {31'd0, ifid_valid}, 1);
    chk("t1_ifid_pc", ifid_pc, 32'h0);
    chk("t1_ifid_npc", ifid_npc, 32'h4);
    chk("t1_ifid_instr", ifid_instr, 32'h20010001);

    // Stall for three cycles with ihit held
    for (int i = 0; i < 3; i++) begin
      drive(32'h4, 1, 32'h22220004, 1, 0, 0, 0);
      #2;
      chk("st_pc_en", {31'd0, pc_en}, 0);
      tick();
      chk("st_hold_pc", ifid_pc, 32'h0);
    end
    drive(32'h4, 1, 32'h22220004, 0, 0, 0, 0);
    #2;
    chk("st_release_pc_en", {31'd0, pc_en}, 1);
    chk("st_release_next", pc_next, 32'h8);
    tick();
    chk("st_release_instr", ifid_instr, 32'h22220004);

    // Memory wait without stall: IF/ID holds, no bubble
    drive(32'h8, 0, 32'hBAD0BAD0, 0, 0, 0, 0);
    tick();
    chk("wait_hold_valid", {31'd0, ifid_valid}, 1);

    // Flush while request outstanding, response two cycles later
    drive(32'h8, 0, 32'hDEADBEEF, 0, 1, 32'h100, 0);
    tick();
    chk("fl_valid", {31'd0, ifid_valid}, 0);
    drive(32'h8, 0, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    tick();
    drive(32'h8, 1, 32'hDEADBEEF, 0, 0, 32'h0, 0);
    #2;
    chk("fl_pc_en", {31'd0, pc_en}, 1);
    chk("fl_pc_next", pc_next, 32'h100);
    tick();
    chk("fl_dropped", {31'd0, ifid_valid}, 0);
    drive(32'h100, 1, 32'h00000111, 0, 0, 0, 0);
    tick();
    chk("fl_resume_pc", ifid_pc, 32'h100);

    // Flush coinciding with ihit in FETCH
    drive(32'h104, 1, 32'hDEAD0001, 0, 1, 32'h300, 0);
    #2;
    chk("flh_pc_next", pc_next, 32'h300);
    tick();

    // Second flush in DISCARD with ihit: newest target wins
    drive(32'h300, 0, 0, 0, 1, 32'h100, 0);
    tick();
    drive(32'h300, 1, 32'hDEAD0002, 0, 1, 32'h200, 0);
    #2;
    chk("f2_pc_next", pc_next, 32'h200);
    tick();
    drive(32'h200, 1, 32'h00000222, 1, 0, 0, 0);
    tick();

    // PC adder wrap
    drive(32'hFFFFFFFC, 1, 32'h0000FFFF, 0, 0, 0, 0);
    #2;
    chk("wr_pc_next", pc_next, 32'h0);
    tick();
    chk("wr_ifid_npc", ifid_npc, 32'h0);

    // Asynchronous reset mid-operation, then 5 fetches plus 2 waits
    #1;
    nRST = 0;
    #1;
    chk("ar_valid", {31'd0, ifid_valid}, 0);
    chk("ar_npc", ifid_npc, 0);
    drive(32'h40, 1, 32'h00000040, 0, 0, 0, 0);
    #1;
    nRST = 1;
    tick();
    drive(32'h44, 1, 32'h00000044, 0, 0, 0, 0); tick();
    drive(32'h48, 0, 32'h0, 0, 0, 0, 0);        tick();
    drive(32'h48, 1, 32'h00000048, 0, 0, 0, 0); tick();
    drive(32'h4C, 1, 32'h0000004C, 0, 0, 0, 0); tick();
    drive(32'h50, 0, 32'h0, 0, 0, 0, 0);        tick();
    drive(32'h50, 1, 32'h00000050, 0, 0, 0, 0); tick();
`ifdef FETCH_PERF_EN
    chk("pf_fetched", perf_fetched, 32'd5);
    chk("pf_wait", perf_wait, 32'd2);
`else
    chk("pf_fetched", perf_fetched, 32'd0);
    chk("pf_wait", perf_wait, 32'd0);
`endif

    // Halt, then flush is ignored
    drive(32'h54, 1, 32'h00000054, 0, 0, 0, 1);
    #2;
    chk("h_pc_en", {31'd0, pc_en}, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(32'h54, 1, 32'h00000055, 0, 1, 32'h400, 0);
      #2;
      chk("h_imemREN", {31'd0, imemREN}, 0);
      chk("h_pc_en_flush", {31'd0, pc_en}, 0);
      chk("h_valid", {31'd0, ifid_valid}, 0);
      tick();
    end
    drive(32'h54, 0, 0, 0, 0, 0, 0);
    nRST = 0;
    #2;
    chk("h_rst_imemREN", {31'd0, imemREN}, 1);
    nRST = 1;
    tick();
    chk("h_after_imemREN", {31'd0, imemREN}, 1);
    tick();

    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage that sits directly downstream of the program counter. It consumes the current PC and drives the instruction-memory request. It loads the IF/ID pipeline register and returns the next PC plus its write enable to the program counter. It handles decode stalls, branch/jump redirects (flush) and halt, including a redirect that arrives while an instruction-memory request is still outstanding.

Parameters:
WORD_W, 32, width of PC, address and instruction words
PC_INCR, 4, sequential PC increment in bytes

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
pc_curr  in  WORD_W  current PC from program counter
pc_next  out  WORD_W  next PC to program counter
pc_en  out  1  program counter update enable
imemREN  out  1  instruction memory read request
imemaddr  out  WORD_W  instruction memory address
ihit  in  1  instruction memory data valid this cycle
imemload  in  WORD_W  instruction memory read data
stall  in  1  decode/hazard stall; IF/ID must hold
flush  in  1  redirect from later stage; kill IF/ID
redirect_pc  in  WORD_W  redirect target, valid when flush=1
halt  in  1  stop fetching until reset
ifid_valid  out  1  IF/ID holds a live instruction
ifid_instr  out  WORD_W  latched instruction
ifid_pc  out  WORD_W  PC of latched instruction
ifid_npc  out  WORD_W  PC + PC_INCR of latched instruction
perf_fetched  out  32  delivered-instruction count (optional feature)
perf_wait  out  32  memory-wait cycle count (optional feature)

Behaviour:
- Clock and reset: one clock, CLK. nRST is asynchronous and active-low.
- Reset state: FSM=FETCH. ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_npc=0. Internal redirect_q=0. Perf counters=0.
- Combinational outputs: pc_en, pc_next, imemREN and imemaddr are combinational from state and inputs. imemaddr=pc_curr always.
- Adder: pc_curr+PC_INCR wraps modulo 2^WORD_W (0xFFFFFFFC -> 0x00000000).
- FSM states: FETCH, DISCARD, HALTED.
- FETCH: imemREN=1.
  - halt=1 (highest priority): next=HALTED, ifid_valid<=0, pc_en=0.
  - else flush=1 and ihit=1: pc_en=1, pc_next=redirect_pc, ifid_valid<=0, data dropped, stay FETCH.
  - else flush=1 and ihit=0: redirect_q<=redirect_pc, ifid_valid<=0, pc_en=0, next=DISCARD.
  - else ihit=1 and stall=0: IF/ID<={1, imemload, pc_curr, pc_curr+PC_INCR}, pc_en=1, pc_next=pc_curr+PC_INCR.
  - else ihit=1 and stall=1: IF/ID holds, pc_en=0; the request stays asserted and is re-served next cycle.
  - else (ihit=0): IF/ID holds, including when stall=0, with no bubble insertion; pc_en=0.
- DISCARD: imemREN=1, waiting out the wrong-path request. Incoming data is never latched.
  - halt=1: next=HALTED.
  - flush=1 again: newest target wins. redirect_q<=redirect_pc; if ihit also high, pc_next uses redirect_pc.
  - ihit=1: pc_en=1, pc_next=redirect_q (or redirect_pc if flush is simultaneous), next=FETCH.
  - ifid_valid stays 0.
- HALTED: imemREN=0, pc_en=0, ifid_valid=0. flush, stall and ihit are ignored. Exit only via nRST.
- pc_next when pc_en=0: pc_curr+PC_INCR; don't-care for checking.
- Latency: one cycle from ihit to ifid_valid. A redirect takes effect on the PC in the cycle of the first ihit at or after the flush.
- Reset mid-operation: asynchronous. All registers return to reset values immediately. Any outstanding memory response is not latched.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined:
  - perf_fetched increments on each cycle IF/ID is loaded with a valid instruction.
  - perf_wait increments on each cycle with imemREN=1 and ihit=0.
  - Both counters are 32-bit wrapping and reset to 0.
- Undefined: both ports are present but tied to 0, and no counter registers are inferred.

Test Plan:
- Reset release, pc_curr=0, ihit held 1, imemload=0x20010001, no stall: cycle 1 pc_en=1, pc_next=4; next edge ifid_valid=1, ifid_pc=0, ifid_npc=4, ifid_instr=0x20010001.
- stall=1 for 3 cycles with ihit=1: pc_en=0 throughout, IF/ID unchanged; the cycle after stall drops, pc_en=1.
- flush=1 with redirect_pc=0x100 and ihit=0, then ihit=1 two cycles later: ifid_valid=0, FSM in DISCARD, imemload ignored; on the ihit cycle pc_en=1, pc_next=0x100, then FETCH.
- Second flush (redirect_pc=0x200) while in DISCARD, same cycle as ihit: pc_next=0x200, not the earlier 0x100.
- halt=1 with ihit=1, then flush=1: next cycle and onward imemREN=0, pc_en=0, ifid_valid=0, flush has no effect; pulsing nRST low restores FETCH with imemREN=1.
- pc_curr=0xFFFFFFFC, ihit=1: pc_next=0x00000000, ifid_npc=0x00000000. With FETCH_PERF_EN, 5 fetches plus 2 wait cycles give perf_fetched=5, perf_wait=2.
